// File: rtl/mmpd_pkg.sv
// mmpd_pkg: shared definitions for the MMPD CDR loop controller.
// State encoding, saturating arithmetic helpers and the default loop
// thresholds that the detector configuration also uses.
package mmpd_pkg;

  // Loop state encoding (kept as fixed 2-bit constants for legacy users)
  typedef logic [1:0] mmpd_state_t;
  localparam mmpd_state_t ST_IDLE  = 2'b00;
  localparam mmpd_state_t ST_ACQ   = 2'b01;
  localparam mmpd_state_t ST_TRACK = 2'b10;

  // Detector output width
  localparam int MMPD_F_W = 16;

  // Default loop thresholds shared with the detector configuration
  localparam int MMPD_ACC_W_DEF      = 24;
  localparam int MMPD_WIN_LOG2_DEF   = 4;
  localparam int MMPD_PHASE_W_DEF    = 7;
  localparam int MMPD_ACQ_SHIFT_DEF  = 6;
  localparam int MMPD_TRK_SHIFT_DEF  = 9;
  localparam int MMPD_MAX_STEP_DEF   = 4;
  localparam int MMPD_LOCK_THR_DEF   = 256;
  localparam int MMPD_LOCK_CNT_DEF   = 8;
  localparam int MMPD_UNLOCK_THR_DEF = 1024;

  // Consecutive noisy windows that drop the loop out of tracking
  localparam int MMPD_UNLOCK_CNT = 2;

  // Second-order path: integrator width, its symmetric limit and gain shift
  localparam int MMPD_FREQ_W     = 12;
  localparam int MMPD_FREQ_LIM   = 2047;
  localparam int MMPD_FREQ_SHIFT = 4;

  // Clamp a signed value into [-lim, +lim]
  function automatic logic signed [31:0] mmpd_clamp(input logic signed [31:0] x,
                                                    input int lim);
    logic signed [31:0] l;
    l = 32'(lim);
    if (x > l)       return l;
    else if (x < -l) return -l;
    else             return x;
  endfunction

  // Signed add saturating symmetrically at +/-lim (no internal overflow)
  function automatic logic signed [31:0] mmpd_sat_add(input logic signed [31:0] a,
                                                      input logic signed [31:0] b,
                                                      input int lim);
    logic signed [32:0] s;
    logic signed [32:0] l;
    s = 33'(a) + 33'(b);
    l = 33'(lim);
    if (s > l)       return 32'(l);
    else if (s < -l) return 32'(-l);
    else             return 32'(s);
  endfunction

endpackage

// File: rtl/mmpd_win_acc.sv
// mmpd_win_acc: saturating window accumulator for the MMPD loop.
// Sums 2^WIN_LOG2 valid detector samples; win_done_o is high for the one
// cycle in which win_sum_o holds the completed window sum. A valid sample
// in that cycle starts the next window without a bubble.
module mmpd_win_acc
  import mmpd_pkg::*;
#(
  parameter int ACC_W    = MMPD_ACC_W_DEF,
  parameter int WIN_LOG2 = MMPD_WIN_LOG2_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr_i,
  input  logic                       vld_i,
  input  logic signed [MMPD_F_W-1:0] f_i,
  output logic                       win_done_o,
  output logic signed [ACC_W-1:0]    win_sum_o
);

  localparam int ACC_LIM = (1 << (ACC_W - 1)) - 1;

  logic signed [ACC_W-1:0]    acc_q, acc_d, base;
  logic        [WIN_LOG2-1:0] cnt_q, cnt_d;
  logic                       done_q, done_d;

  // Next accumulator/counter: restart from zero after a completed window
  always_comb begin
    base   = done_q ? '0 : acc_q;
    acc_d  = base;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (clr_i) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (vld_i) begin
      acc_d  = ACC_W'(mmpd_sat_add(32'(base), 32'(f_i), ACC_LIM));
      cnt_d  = cnt_q + WIN_LOG2'(1);
      done_d = &cnt_q;
    end
  end

  // Accumulator state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign win_done_o = done_q;
  assign win_sum_o  = acc_q;

endmodule

// File: rtl/mmpd_loop_ctrl.sv
// mmpd_loop_ctrl: MMPD phase-detector loop sequencer for the CDR.
// Converts each window sum into a clamped phase-code step, runs the
// IDLE/ACQ/TRACK lock machine and drives the detector beta enable.
// Optional second-order frequency path: define MMPD_LOOP_FREQ_INT_EN.
module mmpd_loop_ctrl
  import mmpd_pkg::*;
#(
  parameter int ACC_W      = MMPD_ACC_W_DEF,
  parameter int WIN_LOG2   = MMPD_WIN_LOG2_DEF,
  parameter int PHASE_W    = MMPD_PHASE_W_DEF,
  parameter int ACQ_SHIFT  = MMPD_ACQ_SHIFT_DEF,
  parameter int TRK_SHIFT  = MMPD_TRK_SHIFT_DEF,
  parameter int MAX_STEP   = MMPD_MAX_STEP_DEF,
  parameter int LOCK_THR   = MMPD_LOCK_THR_DEF,
  parameter int LOCK_CNT   = MMPD_LOCK_CNT_DEF,
  parameter int UNLOCK_THR = MMPD_UNLOCK_THR_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       sym_valid,
  input  logic signed [MMPD_F_W-1:0] f_n,
  output logic [PHASE_W-1:0]         phase_code,
  output logic                       phase_upd,
  output logic                       beta_en,
  output logic                       locked,
  output logic [1:0]                 state
);

  localparam int QW = $clog2(LOCK_CNT + 1);

  mmpd_state_t          state_q, state_d;
  logic [PHASE_W-1:0]   phase_q, phase_d;
  logic                 upd_q, upd_d;
  logic                 beta_q, beta_d;
  logic                 locked_q, locked_d;
  logic [QW-1:0]        quiet_q, quiet_d, quiet_inc;
  logic [1:0]           noisy_q, noisy_d, noisy_inc;

  logic                 acc_clr;
  logic                 win_done;
  logic signed [ACC_W-1:0] win_sum;
  logic signed [31:0]   sum32, sh32, abs32, step_raw, step_app;
  logic                 is_quiet, is_noisy;

  // IDLE (or en low) keeps the accumulator flushed, so samples seen
  // during IDLE and any partial sum on dropping en are discarded.
  assign acc_clr = !en || (state_q == ST_IDLE);

  mmpd_win_acc #(
    .ACC_W    (ACC_W),
    .WIN_LOG2 (WIN_LOG2)
  ) u_acc (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (acc_clr),
    .vld_i      (sym_valid),
    .f_i        (f_n),
    .win_done_o (win_done),
    .win_sum_o  (win_sum)
  );

  // Window sum classification and first-order step
  always_comb begin
    sum32    = 32'(win_sum);
    sh32     = (state_q == ST_ACQ) ? (sum32 >>> ACQ_SHIFT) : (sum32 >>> TRK_SHIFT);
    step_raw = mmpd_clamp(sh32, MAX_STEP);
    abs32    = sum32[31] ? -sum32 : sum32;
    is_quiet = abs32 < 32'(LOCK_THR);
    is_noisy = abs32 >= 32'(UNLOCK_THR);
  end

`ifdef MMPD_LOOP_FREQ_INT_EN
  logic signed [MMPD_FREQ_W-1:0] freq_q, freq_d, freq_nxt;
  logic signed [31:0]            freq_ext;

  // Second-order path: integrator output (pre-update value) adds to the step
  always_comb begin
    freq_ext = 32'(freq_q);
    step_app = mmpd_clamp(step_raw + (freq_ext >>> MMPD_FREQ_SHIFT), MAX_STEP);
    freq_nxt = MMPD_FREQ_W'(mmpd_sat_add(freq_ext, step_raw, MMPD_FREQ_LIM));
  end
`else
  assign step_app = step_raw;
`endif

  assign quiet_inc = (quiet_q == QW'(LOCK_CNT)) ? quiet_q : quiet_q + QW'(1);
  assign noisy_inc = (noisy_q == 2'(MMPD_UNLOCK_CNT)) ? noisy_q : noisy_q + 2'd1;

  // Lock state machine and phase update; en low overrides a window end
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    upd_d    = 1'b0;
    beta_d   = beta_q;
    locked_d = locked_q;
    quiet_d  = quiet_q;
    noisy_d  = noisy_q;
`ifdef MMPD_LOOP_FREQ_INT_EN
    freq_d   = freq_q;
`endif
    if (!en) begin
      state_d  = ST_IDLE;
      beta_d   = 1'b0;
      locked_d = 1'b0;
      quiet_d  = '0;
      noisy_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_ACQ;
`ifdef MMPD_LOOP_FREQ_INT_EN
          freq_d  = '0;
`endif
        end
        ST_ACQ, ST_TRACK: begin
          if (win_done) begin
            phase_d = PHASE_W'(32'(phase_q) + step_app);
            upd_d   = (step_app != '0);
            quiet_d = is_quiet ? quiet_inc : '0;
            noisy_d = is_noisy ? noisy_inc : '0;
`ifdef MMPD_LOOP_FREQ_INT_EN
            freq_d  = freq_nxt;
`endif
            if ((state_q == ST_ACQ) && (quiet_d == QW'(LOCK_CNT))) begin
              state_d  = ST_TRACK;
              locked_d = 1'b1;
              beta_d   = 1'b1;
            end else if ((state_q == ST_TRACK) &&
                         (noisy_d == 2'(MMPD_UNLOCK_CNT))) begin
              state_d  = ST_ACQ;
              locked_d = 1'b0;
              beta_d   = 1'b0;
              quiet_d  = '0;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Controller state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      phase_q  <= '0;
      upd_q    <= 1'b0;
      beta_q   <= 1'b0;
      locked_q <= 1'b0;
      quiet_q  <= '0;
      noisy_q  <= '0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      upd_q    <= upd_d;
      beta_q   <= beta_d;
      locked_q <= locked_d;
      quiet_q  <= quiet_d;
      noisy_q  <= noisy_d;
    end
  end

`ifdef MMPD_LOOP_FREQ_INT_EN
  // Frequency integrator register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) freq_q <= '0;
    else     freq_q <= freq_d;
  end
`endif

  assign phase_code = phase_q;
  assign phase_upd  = upd_q;
  assign beta_en    = beta_q;
  assign locked     = locked_q;
  assign state      = state_q;

endmodule

// File: tb/tb_mmpd_loop_ctrl.sv
// tb_mmpd_loop_ctrl: directed self-checking bench for mmpd_loop_ctrl.
// Main instance uses default parameters; a second instance with ACC_W=16
// shares the stimulus and is used for the accumulator saturation case.
module tb_mmpd_loop_ctrl;

  logic clk;
  logic rst;
  logic en;
  logic sym_valid;
  logic signed [15:0] f_n;

  logic [6:0] phase_code, phase_code16;
  logic phase_upd, phase_upd16;
  logic beta_en, beta_en16;
  logic locked, locked16;
  logic [1:0] state, state16;

  mmpd_loop_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .sym_valid  (sym_valid),
    .f_n        (f_n),
    .phase_code (phase_code),
    .phase_upd  (phase_upd),
    .beta_en    (beta_en),
    .locked     (locked),
    .state      (state)
  );

  mmpd_loop_ctrl #(.ACC_W(16)) dut16 (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .sym_valid  (sym_valid),
    .f_n        (f_n),
    .phase_code (phase_code16),
    .phase_upd  (phase_upd16),
    .beta_en    (beta_en16),
    .locked     (locked16),
    .state      (state16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int phase;
    int upd;
  } exp_t;

  exp_t sb[$];
  int   n_err    = 0;
  int   n_checks = 0;
  int   exp_phase = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int model_step(input int sum, input int shift);
    int s;
    s = sum >>> shift;
    if (s > 4)  s = 4;
    if (s < -4) s = -4;
    return s;
  endfunction

  // Drive 16 valid samples alternating a,b; model the resulting step
  task automatic window(input int a, input int b, input int shift, input bit push);
    int sum;
    int step;
    exp_t e;
    sum = 0;
    for (int i = 0; i < 16; i++) begin
      sym_valid = 1'b1;
      f_n = (i % 2 == 0) ? 16'(a) : 16'(b);
      sum += (i % 2 == 0) ? a : b;
      @(negedge clk);
    end
    step = model_step(sum, shift);
    exp_phase = (exp_phase + step) & 127;
    if (push) begin
      e.phase = exp_phase;
      e.upd   = (step != 0) ? 1 : 0;
      sb.push_back(e);
    end
  endtask

  // Idle the window-end cycle, then compare against the oldest expectation
  task automatic finish_window(input string tag);
    exp_t e;
    sym_valid = 1'b0;
    f_n = '0;
    @(negedge clk);
    n_checks++;
    if (sb.size() == 0) begin
      n_err++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, "_phase"},   32'(phase_code),   32'(e.phase));
      check({tag, "_phase16"}, 32'(phase_code16), 32'(e.phase));
      check({tag, "_upd"},     32'(phase_upd),    32'(e.upd));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b0; sym_valid = 1'b0; f_n = '0;
    repeat (3) @(negedge clk);
    check("rst_phase",  32'(phase_code), 32'd0);
    check("rst_upd",    32'(phase_upd),  32'd0);
    check("rst_beta",   32'(beta_en),    32'd0);
    check("rst_locked", 32'(locked),     32'd0);
    check("rst_state",  32'(state),      32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_hold", 32'(state), 32'd0);

    // Window of +8: sum 128, step 2 in ACQ
    en = 1'b1;
    @(negedge clk);
    check("t1_acq", 32'(state), 32'd1);
    window(8, 8, 6, 1);
    finish_window("t1");
    @(negedge clk);
    check("t1_upd_pulse", 32'(phase_upd), 32'd0);

    // Reset, then -200 window: step clamps to -4, code wraps to 124
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_phase = 0;
    check("t2_rst_phase", 32'(phase_code), 32'd0);
    @(negedge clk);
    check("t2_acq", 32'(state), 32'd1);
    window(-200, -200, 6, 1);
    finish_window("t2");

    // Eight quiet windows of alternating +/-10 -> TRACK with lock
    for (int w = 0; w < 7; w++) begin
      window(10, -10, 6, 1);
      finish_window("t3");
    end
    check("t3_pre_state",  32'(state),  32'd1);
    check("t3_pre_locked", 32'(locked), 32'd0);
    window(10, -10, 6, 1);
    finish_window("t3_8th");
    check("t3_state",  32'(state),   32'd2);
    check("t3_locked", 32'(locked),  32'd1);
    check("t3_beta",   32'(beta_en), 32'd1);

    // TRACK: noisy, quiet, noisy keeps lock; second consecutive noisy unlocks
    window(100, 100, 9, 1);
    finish_window("t4_n1");
    check("t4_n1_state", 32'(state), 32'd2);
    window(0, 0, 9, 1);
    finish_window("t4_q");
    window(100, 100, 9, 1);
    finish_window("t4_n2");
    check("t4_n2_state",  32'(state),  32'd2);
    check("t4_n2_locked", 32'(locked), 32'd1);
    window(100, 100, 9, 1);
    finish_window("t4_n3");
    check("t4_state",  32'(state),   32'd1);
    check("t4_locked", 32'(locked),  32'd0);
    check("t4_beta",   32'(beta_en), 32'd0);

    // en dropped together with the 16th sample: IDLE wins
    for (int i = 0; i < 15; i++) begin
      sym_valid = 1'b1; f_n = 16'sd8;
      @(negedge clk);
    end
    en = 1'b0;
    @(negedge clk);
    sym_valid = 1'b0;
    check("t5_state", 32'(state),             32'd0);
    check("t5_upd",   32'(phase_upd),         32'd0);
    check("t5_phase", 32'(phase_code),        32'(exp_phase));
    check("t5_acc",   32'(dut.u_acc.acc_q),   32'd0);
    check("t5_cnt",   32'(dut.u_acc.cnt_q),   32'd0);
    @(negedge clk);
    check("t5_upd2",  32'(phase_upd),         32'd0);
    // Valid sample during the IDLE->ACQ cycle must be ignored
    en = 1'b1; sym_valid = 1'b1; f_n = 16'sd1000;
    @(negedge clk);
    check("t5_acq", 32'(state), 32'd1);
    window(8, 8, 6, 1);
    finish_window("t5_win");

    // Full-scale samples: ACC_W=16 instance saturates at 32767
    window(32767, 32767, 6, 1);
    check("t6_acc16", 32'(dut16.u_acc.acc_q), 32'd32767);
    check("t6_acc24", 32'(dut.u_acc.acc_q),   32'd524272);
    finish_window("t6");

    // Back-to-back windows: no bubble between them
    window(8, 8, 6, 0);
    window(8, 8, 6, 1);
    finish_window("t7");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
